// File: rtl/mul32_seq_pkg.sv
// Shared constants for the iterative shift-add multiplier: state encoding,
// iteration count and counter width.
package mul32_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = 5;

endpackage

// File: rtl/mul32_seq.sv
// Iterative 32x32 shift-add multiplier with start/busy/done handshake.
// Signed operands are handled as sign-magnitude and the product negated at the end.
module mul32_seq
    import mul32_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic               neg;

    // Magnitudes are kept unsigned, so |0x80000000| stays 0x80000000 without overflow.
    always_comb begin
        mag_a    = (signed_op && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
        mag_b    = (signed_op && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        neg    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Counter wraps to zero on this final step.
                    if (cnt == CNT_W'(MUL_ITERS - 1)) begin
                        prod  <= neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign prod_lo = prod[WIDTH-1:0];
    assign prod_hi = prod[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed vector table, randomized
// operands against a 64-bit arithmetic model, and start-ignore / reset sequences.
module tb_mul32_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] prod_lo;
    logic [31:0] prod_hi;

    int          nChecks;
    int          nFails;
    logic [63:0] expPrev;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] expProd;
        string       name;
    } vec_t;

    vec_t vecs [10];

    mul32_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .prod_lo   (prod_lo),
        .prod_hi   (prod_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        wb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        return wa * wb;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one multiply, then check latency, busy length, held output and result.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input logic [63:0] exp, input string name);
        int lat;
        int busyCnt;
        int overlaps;
        logic [63:0] midProd;
        lat      = 0;
        busyCnt  = 0;
        overlaps = 0;
        midProd  = '0;
        @(negedge clk);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        signed_op = sgn;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        signed_op = $urandom_range(0, 1);
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busyCnt++;
            if (busy && done) overlaps++;
            if (lat == 16) midProd = {prod_hi, prod_lo};
            if (done) break;
        end
        checkOutput({name, " latency"}, 64'(lat), 64'd33);
        checkOutput({name, " busy_cycles"}, 64'(busyCnt), 64'd32);
        checkOutput({name, " busy_done_overlap"}, 64'(overlaps), 64'd0);
        checkOutput({name, " held_prev"}, midProd, expPrev);
        checkOutput({name, " product"}, {prod_hi, prod_lo}, exp);
        expPrev = exp;
    endtask

    initial begin
        nChecks   = 0;
        nFails    = 0;
        expPrev   = '0;
        resetn    = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = '0;
        op_b      = '0;

        vecs[0] = '{32'd3,        32'd5,        1'b0, 64'h00000000_0000000F, "u3x5"};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "uFFxFF"};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, "sm1xm1"};
        vecs[3] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFF_FFFFFFFA, "sm2x3"};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "sminxmin"};
        vecs[5] = '{32'h00000000, 32'h12345678, 1'b0, 64'h00000000_00000000, "u0xN"};
        vecs[6] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, "sminx1"};
        vecs[7] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000, "smaxxmin"};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000, "u8x8"};
        vecs[9] = '{32'h00000005, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFF1, "s5xm3"};

        #3;
        checkOutput("reset_busy_done", {62'h0, busy, done}, 64'h0);
        checkOutput("reset_prod", {prod_hi, prod_lo}, 64'h0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i])
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].expProd, vecs[i].name);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rs = $urandom_range(0, 1);
            if (i % 8 == 0) ra = 32'h80000000;
            if (i % 8 == 1) rb = 32'hFFFFFFFF;
            applyStimulus(ra, rb, rs, refProduct(ra, rb, rs), "rand");
        end

        // Start pulses during RUN and DONE must be dropped, leaving one done pulse.
        begin
            int busyCnt;
            int doneCnt;
            int doneCyc;
            busyCnt = 0;
            doneCnt = 0;
            doneCyc = 0;
            @(negedge clk);
            start     = 1'b1;
            signed_op = 1'b0;
            op_a      = 32'd7;
            op_b      = 32'd9;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int cyc = 1; cyc <= 80; cyc++) begin
                @(negedge clk);
                if (busy) busyCnt++;
                if (done) begin
                    doneCnt++;
                    doneCyc = cyc;
                end
                start = (cyc == 5) || done;
                if (start) begin
                    op_a = 32'd2;
                    op_b = 32'd2;
                end
            end
            start = 1'b0;
            checkOutput("ignore_done_count", 64'(doneCnt), 64'd1);
            checkOutput("ignore_done_cycle", 64'(doneCyc), 64'd33);
            checkOutput("ignore_busy_cycles", 64'(busyCnt), 64'd32);
            checkOutput("ignore_product", {prod_hi, prod_lo}, 64'd63);
            expPrev = 64'd63;
        end

        // Reset mid-RUN clears outputs at once and aborts the operation.
        applyStimulus(32'd6, 32'd7, 1'b0, 64'd42, "u6x7");
        begin
            int busyCnt;
            int doneCnt;
            busyCnt = 0;
            doneCnt = 0;
            @(negedge clk);
            start = 1'b1;
            op_a  = 32'd9;
            op_b  = 32'd9;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (10) @(negedge clk);
            resetn = 1'b0;
            #1;
            checkOutput("abort_busy_done", {62'h0, busy, done}, 64'h0);
            checkOutput("abort_prod", {prod_hi, prod_lo}, 64'h0);
            @(negedge clk);
            resetn  = 1'b1;
            expPrev = '0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                if (busy) busyCnt++;
                if (done) doneCnt++;
            end
            checkOutput("abort_no_busy", 64'(busyCnt), 64'd0);
            checkOutput("abort_no_done", 64'(doneCnt), 64'd0);
        end
        applyStimulus(32'd4, 32'd4, 1'b0, 64'd16, "u4x4");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
